// File: rtl/shortfifo.sv
// shortfifo: small first-word-fall-through FIFO, one clock domain.
// Storage is 2**aw words. The head word is read combinationally.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   din, we    : write data and write enable
//   dout, re   : head data (0 when empty) and pop enable
//   full       : set when count == 2**aw
//   empty      : set when count == 0
//   count      : number of stored words, 0 .. 2**aw
module shortfifo #(
  parameter int dw = 8,
  parameter int aw = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [dw-1:0] din,
  input  logic          we,
  output logic [dw-1:0] dout,
  input  logic          re,
  output logic          full,
  output logic          empty,
  output logic [aw:0]   count
);

  localparam int depth = 2**aw;

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  // count never exceeds depth, so its top bit alone marks full
  assign full  = count[aw];
  assign empty = (count == '0);

  // a pop frees a slot in the same edge, so a full FIFO
  // still accepts a write when re is high
  assign wr_ok = we & (~full | re);
  assign rd_ok = re & ~empty;

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count
             + {{aw{1'b0}}, wr_ok}
             - {{aw{1'b0}}, rd_ok};
    end
  end

endmodule

// File: tb/tb_shortfifo.sv
// tb_shortfifo: directed vectors, corner sequences
// and a random ordering soak for shortfifo.
module tb_shortfifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       we;
  logic [7:0] dout;
  logic       re;
  logic       full;
  logic       empty;
  logic [3:0] count;

  int npass;
  int ntot;

  shortfifo #(.dw(8), .aw(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .we    (we),
    .dout  (dout),
    .re    (re),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [7:0] xdout;
    logic [3:0] xcnt;
    logic       xemp;
    logic       xful;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input int got, input int exp);
    ntot++;
    if (got == exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    we  = w;
    re  = r;
    din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic [7:0] xd,
                           input logic [3:0] xc, input logic xe,
                           input logic xf);
    check({nm, ".dout"},  int'(dout),  int'(xd));
    check({nm, ".count"}, int'(count), int'(xc));
    check({nm, ".empty"}, int'(empty), int'(xe));
    check({nm, ".full"},  int'(full),  int'(xf));
  endtask

  initial begin
    int wr_val;
    int rd_val;
    int mcnt;
    int soak_fail;
    logic w;
    logic r;
    npass = 0;
    ntot  = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    din   = 8'h00;

    // fall-through, read on empty, simultaneous ops
    vecs[0] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 4'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h33, 8'h33, 4'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h44, 8'h44, 4'd1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'h77, 8'h77, 4'd1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0};

    #12;
    chk_state("reset", 8'h00, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      chk_state($sformatf("vec%0d", i), vecs[i].xdout,
                vecs[i].xcnt, vecs[i].xemp, vecs[i].xful);
    end

    // fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check($sformatf("fill%0d.count", i), int'(count), i);
    end
    chk_state("full", 8'h01, 4'd8, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hEE);
    chk_state("drop", 8'h01, 4'd8, 1'b0, 1'b1);
    // pop and push together while full
    step(1'b1, 1'b1, 8'h09);
    chk_state("fullrw", 8'h02, 4'd8, 1'b0, 1'b1);
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("pop%0d", i), int'(dout), i);
      step(1'b0, 1'b1, 8'h00);
    end
    chk_state("drained", 8'h00, 4'd0, 1'b1, 1'b0);

    // reset mid-operation
    step(1'b1, 1'b0, 8'hAA);
    step(1'b1, 1'b0, 8'hBB);
    step(1'b1, 1'b0, 8'hCC);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("midrst", 8'h00, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hDD);
    step(1'b1, 1'b0, 8'hDE);
    chk_state("postrst", 8'hDD, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    check("postrst.pop2", int'(dout), 8'hDE);
    step(1'b0, 1'b1, 8'h00);
    check("postrst.empty", int'(empty), 1);

    // random soak: two phases, second drains
    wr_val    = 0;
    rd_val    = 0;
    mcnt      = 0;
    soak_fail = 0;
    for (int i = 0; i < 300; i++) begin
      int pct;
      pct = (i < 150) ? 50 : 25;
      @(negedge clk);
      w = ($urandom_range(99) < pct) && (mcnt != 8);
      r = ($urandom_range(99) < 50) && (mcnt != 0);
      if (r) begin
        if (int'(dout) != (rd_val & 8'hFF)) soak_fail++;
        check("soak.dout", int'(dout), rd_val & 8'hFF);
        rd_val++;
      end
      we  = w;
      re  = r;
      din = 8'(wr_val);
      if (w) wr_val++;
      mcnt = mcnt + int'(w) - int'(r);
      @(posedge clk);
      #1;
      we = 1'b0;
      re = 1'b0;
      if (int'(count) != mcnt) soak_fail++;
      check("soak.count", int'(count), mcnt);
    end
    if (soak_fail == 0) begin
      $display("soak PASS (%0d pops)", rd_val);
    end else begin
      $display("FAIL soak: %0d errors, expected 0", soak_fail);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
